// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one 32-bit ALU between two requesters.
// One operation in flight: accept in IDLE, execute for one cycle, hold the response until it is taken.
module alu_arbiter #(
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_src1_i,
    input  logic [31:0] req0_src2_i,
    input  logic [3:0]  req0_ctrl_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_src1_i,
    input  logic [31:0] req1_src2_i,
    input  logic [3:0]  req1_ctrl_i,

    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    output logic [3:0]  alu_ctrl_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_result_o,
    output logic        rsp_zero_o,

    output logic [1:0]  state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // requesters hold valid and payload stable until ready, and the response holds until rsp_ready_i.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        prio_q;
    logic        id_q;
    logic [31:0] src1_q, src2_q;
    logic [3:0]  ctrl_q;
    logic [31:0] result_q;
    logic        zero_q;

    logic        grant_id;
    logic        accept;

    // Requester 1 wins when it is alone or when both ask and the pointer favours it.
    assign grant_id = req1_valid_i & (~req0_valid_i | prio_q);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                // Ready stays low while reset is held, even though the state already reads IDLE.
                if (rst_i && (req0_valid_i || req1_valid_i)) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req0_ready_o = accept & ~grant_id;
    assign req1_ready_o = accept & grant_id;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            prio_q   <= RESET_PRIO;
            id_q     <= 1'b0;
            src1_q   <= 32'd0;
            src2_q   <= 32'd0;
            ctrl_q   <= 4'd0;
            result_q <= 32'd0;
            zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q   <= grant_id;
                prio_q <= ~grant_id;
                src1_q <= grant_id ? req1_src1_i : req0_src1_i;
                src2_q <= grant_id ? req1_src2_i : req0_src2_i;
                ctrl_q <= grant_id ? req1_ctrl_i : req0_ctrl_i;
            end
            if (state_q == EXEC) begin
                result_q <= alu_result_i;
                zero_q   <= alu_zero_i;
            end
        end
    end

    assign alu_src1_o   = src1_q;
    assign alu_src2_o   = src2_q;
    assign alu_ctrl_o   = ctrl_q;

    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_id_o     = id_q;
    assign rsp_result_o = result_q;
    assign rsp_zero_o   = zero_q;

    assign state_o      = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, transaction-level arbitration model,
// expected-response queue and a monitor that compares every presented response.
module tb_alu_arbiter;

    localparam bit RP = 1'b0;

    typedef struct {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [3:0]  c;
        int          gap;
    } op_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic        req0_ready_o, req1_ready_o;
    logic [31:0] req0_src1_i = '0, req0_src2_i = '0, req1_src1_i = '0, req1_src2_i = '0;
    logic [3:0]  req0_ctrl_i = '0, req1_ctrl_i = '0;
    logic [31:0] alu_src1_o, alu_src2_o, alu_result_i;
    logic [3:0]  alu_ctrl_o;
    logic        alu_zero_i;
    logic        rsp_valid_o, rsp_id_o, rsp_zero_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_result_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_mode = 0;
    bit busy0 = 0, busy1 = 0;

    op_t         rq0[$];
    op_t         rq1[$];
    logic [33:0] exp_q[$];
    logic [33:0] seen_q[$];
    int          acc_cyc[$];

    int          m_stage = 0;
    bit          m_prio = RP;
    bit          e0, e1, win;
    logic [31:0] m_res;

    alu_arbiter #(.RESET_PRIO(RP)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_src1_i(req0_src1_i), .req0_src2_i(req0_src2_i), .req0_ctrl_i(req0_ctrl_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_src1_i(req1_src1_i), .req1_src2_i(req1_src2_i), .req1_ctrl_i(req1_ctrl_i),
        .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o),
        .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic apply_reset();
        @(posedge clk_i); #1 rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
    endtask

    // ---------------- external ALU model ----------------
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a ^ b ^ {28'd0, c};
        endcase
    endfunction

    assign alu_result_i = alu_fn(alu_src1_o, alu_src2_o, alu_ctrl_o);
    assign alu_zero_i   = (alu_result_i == 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int n, input logic v, input op_t op);
        if (n == 0) begin
            req0_valid_i = v; req0_src1_i = op.s1; req0_src2_i = op.s2; req0_ctrl_i = op.c;
        end else begin
            req1_valid_i = v; req1_src1_i = op.s1; req1_src2_i = op.s2; req1_ctrl_i = op.c;
        end
    endtask

    task automatic run_driver(input int n);
        op_t op;
        bit  hs;
        int  budget;
        forever begin
            if ((n == 0 && rq0.size() == 0) || (n == 1 && rq1.size() == 0)) begin
                @(posedge clk_i); #1;
            end else begin
                if (n == 0) begin op = rq0.pop_front(); busy0 = 1; end
                else        begin op = rq1.pop_front(); busy1 = 1; end
                repeat (op.gap) begin @(posedge clk_i); #1; end
                set_req(n, 1'b1, op);
                hs = 0;
                budget = 0;
                while (!hs && budget < 300) begin
                    @(negedge clk_i);
                    hs = (n == 0) ? req0_ready_o : req1_ready_o;
                    @(posedge clk_i); #1;
                    budget++;
                end
                if (!hs) chk($sformatf("req%0d_accept_timeout", n), 32'd0, 32'd1);
                set_req(n, 1'b0, op);
                if (n == 0) busy0 = 0; else busy1 = 0;
            end
        end
    endtask

    // Response consumer: always ready, random, or stalled.
    initial forever begin
        @(posedge clk_i); #1;
        rsp_ready_i = (rsp_mode == 0) ? 1'b1 : (rsp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // ---------------- reference model (transaction level) ----------------
    // The shared unit is either free, executing, or presenting a response; a free unit
    // accepts the lone requester, or the favoured one when both ask, and then favours the other.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            m_stage = 0;
            m_prio  = RP;
            exp_q.delete();
        end else begin
            e0 = (m_stage == 0) && req0_valid_i && (!req1_valid_i || m_prio == 1'b0);
            e1 = (m_stage == 0) && req1_valid_i && (!req0_valid_i || m_prio == 1'b1);
            chk("req0_ready", 32'(req0_ready_o), 32'(e0));
            chk("req1_ready", 32'(req1_ready_o), 32'(e1));
            chk("rsp_valid", 32'(rsp_valid_o), 32'(m_stage == 2));
            case (m_stage)
                0: if (e0 || e1) begin
                    win   = e1;
                    m_res = win ? alu_fn(req1_src1_i, req1_src2_i, req1_ctrl_i)
                                : alu_fn(req0_src1_i, req0_src2_i, req0_ctrl_i);
                    exp_q.push_back({win, (m_res == 32'd0), m_res});
                    acc_cyc.push_back(cyc);
                    m_prio  = !win;
                    m_stage = 1;
                end
                1: m_stage = 2;
                default: if (rsp_ready_i) m_stage = 0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [33:0] head;
    always @(negedge clk_i) begin
        if (rst_i && rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
            end else begin
                head = exp_q[0];
                chk("rsp_id", 32'(rsp_id_o), 32'(head[33]));
                chk("rsp_zero", 32'(rsp_zero_o), 32'(head[32]));
                chk("rsp_result", rsp_result_o, head[31:0]);
                if (rsp_ready_i) begin
                    void'(exp_q.pop_front());
                    seen_q.push_back({rsp_id_o, rsp_zero_o, rsp_result_o});
                end
            end
        end
    end

    task automatic wait_done(input int limit);
        int t = 0;
        while ((rq0.size() != 0 || rq1.size() != 0 || busy0 || busy1 || exp_q.size() != 0 || m_stage != 0)
               && t < limit) begin
            @(posedge clk_i);
            t++;
        end
        #1;
        chk("drain_timeout", 32'(t >= limit), 32'd0);
    endtask

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c, input int g);
        op_t o;
        o.s1 = a; o.s2 = b; o.c = c; o.gap = g;
        return o;
    endfunction

    function automatic logic [3:0] rnd_ctrl();
        case ($urandom_range(0, 7))
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0010;
            3: return 4'b0110;
            4: return 4'b0111;
            5: return 4'b0011;
            6: return 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req0_ready"}, 32'(req0_ready_o), 32'd0);
        chk({tag, "_req1_ready"}, 32'(req1_ready_o), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id_o), 32'd0);
        chk({tag, "_rsp_result"}, rsp_result_o, 32'd0);
        chk({tag, "_rsp_zero"}, 32'(rsp_zero_o), 32'd0);
        chk({tag, "_alu_src1"}, alu_src1_o, 32'd0);
        chk({tag, "_alu_src2"}, alu_src2_o, 32'd0);
        chk({tag, "_alu_ctrl"}, 32'(alu_ctrl_o), 32'd0);
        chk({tag, "_state"}, 32'(state_o), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] r;
    int t;
    initial begin
        fork
            run_driver(0);
            run_driver(1);
        join_none

        // Reset values with both valids asserted: no ready may leak out.
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #2 check_reset_outputs("reset");
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        @(posedge clk_i); #1 rst_i = 1'b1;

        // Single add from requester 0.
        seen_q.delete();
        rq0.push_back(mk(32'h5, 32'h3, 4'b0010, 0));
        wait_done(100);
        chk("add_count", seen_q.size(), 1);
        if (seen_q.size() >= 1) chk("add_rsp", seen_q[0], {1'b0, 1'b0, 32'h8});

        // Subtract to zero from requester 1.
        seen_q.delete();
        rq1.push_back(mk(32'h12345678, 32'h12345678, 4'b0110, 0));
        wait_done(100);
        chk("sub_count", seen_q.size(), 1);
        if (seen_q.size() >= 1) chk("sub_rsp", seen_q[0], {1'b1, 1'b1, 32'h0});

        // Simultaneous requests right after reset.
        apply_reset();
        seen_q.delete();
        acc_cyc.delete();
        rq0.push_back(mk(32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 0));
        rq1.push_back(mk(32'h0000000F, 32'h000000F0, 4'b0001, 0));
        wait_done(100);
        chk("simul_count", seen_q.size(), 2);
        if (seen_q.size() >= 2) begin
            chk("simul_first", seen_q[0], {1'b0, 1'b0, 32'hF000F000});
            chk("simul_second", seen_q[1], {1'b1, 1'b0, 32'h000000FF});
        end
        if (acc_cyc.size() >= 2) chk("simul_gap", acc_cyc[1] - acc_cyc[0], 3);

        // Continuous contention: grants alternate every 3 cycles.
        seen_q.delete();
        acc_cyc.delete();
        for (int i = 0; i < 2; i++) begin
            rq0.push_back(mk($urandom, $urandom, rnd_ctrl(), 0));
            rq1.push_back(mk($urandom, $urandom, rnd_ctrl(), 0));
        end
        wait_done(100);
        chk("cont_count", seen_q.size(), 4);
        for (int i = 0; i < 4 && i < seen_q.size(); i++) chk($sformatf("cont_id%0d", i), 32'(seen_q[i][33]), i % 2);
        for (int i = 1; i < 4 && i < acc_cyc.size(); i++) chk($sformatf("cont_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 3);

        // Response stall with requester 1 waiting.
        seen_q.delete();
        acc_cyc.delete();
        rsp_mode = 2;
        rq0.push_back(mk(32'd100, 32'd58, 4'b0110, 0));
        rq1.push_back(mk(32'd7, 32'd9, 4'b0010, 2));
        repeat (10) @(posedge clk_i);
        #1 chk("stall_no_second", acc_cyc.size(), 1);
        rsp_mode = 0;
        wait_done(100);
        chk("stall_count", seen_q.size(), 2);
        if (seen_q.size() >= 2) begin
            chk("stall_first", seen_q[0], {1'b0, 1'b0, 32'd42});
            chk("stall_second", seen_q[1], {1'b1, 1'b0, 32'd16});
        end

        // Reset during EXEC discards the operation.
        seen_q.delete();
        rq0.push_back(mk(32'd1, 32'd2, 4'b0111, 0));
        t = 0;
        do begin @(negedge clk_i); t++; end while (!req0_ready_o && t < 50);
        chk("rmid_accept", 32'(req0_ready_o), 32'd1);
        @(posedge clk_i);
        #2 rst_i = 1'b0;
        #1 check_reset_outputs("rmid");
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        repeat (6) @(posedge clk_i);
        #1 chk("rmid_no_rsp", seen_q.size(), 0);
        rq0.push_back(mk(32'd1, 32'd2, 4'b0111, 0));
        wait_done(100);
        chk("rmid_redo_count", seen_q.size(), 1);
        if (seen_q.size() >= 1) chk("rmid_redo", seen_q[0], {1'b0, 1'b0, 32'd1});

        // Randomized traffic with a random consumer.
        seen_q.delete();
        rsp_mode = 1;
        for (int i = 0; i < 30; i++) begin
            r = $urandom;
            rq0.push_back(mk(r, ($urandom_range(0, 3) == 0) ? r : $urandom, rnd_ctrl(), $urandom_range(0, 4)));
            r = $urandom;
            rq1.push_back(mk(r, ($urandom_range(0, 3) == 0) ? r : $urandom, rnd_ctrl(), $urandom_range(0, 4)));
        end
        wait_done(3000);
        chk("rand_count", seen_q.size(), 60);
        rsp_mode = 0;

        repeat (2) @(posedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit ALU between two requesters, such as the datapath issue port and a secondary unit like an address or compare helper. The block arbitrates round-robin and captures the granted operands and control code. It drives them to the ALU for one execute cycle, registers the ALU result and zero flag, and returns them with the requester ID through a valid/ready response channel. Only one operation is in flight at a time.

## Interface
- RESET_PRIO, 0, requester favoured by the round-robin pointer after reset (0 or 1)
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-low
- req0_valid_i  input  1  requester 0 has an operation
- req0_ready_o  output  1  requester 0 operation accepted this cycle
- req0_src1_i / req0_src2_i  input  32  requester 0 operands
- req0_ctrl_i  input  4  requester 0 ALU control code
- req1_valid_i, req1_ready_o, req1_src1_i, req1_src2_i, req1_ctrl_i  same widths and meaning as requester 0, for requester 1
- alu_src1_o / alu_src2_o  output  32  operands to the ALU
- alu_ctrl_o  output  4  control code to the ALU
- alu_result_i  input  32  ALU result (combinational from alu_* outputs)
- alu_zero_i  input  1  ALU zero flag
- rsp_valid_o  output  1  response available
- rsp_ready_i  input  1  consumer takes the response
- rsp_id_o  output  1  requester that issued the response
- rsp_result_o  output  32  registered ALU result
- rsp_zero_o  output  1  registered ALU zero flag

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE:**
  - Grant is computed combinationally from the valids and the priority pointer `prio`.
  - If only one valid is high, that requester wins.
  - If both are high, requester `prio` wins.
  - `reqN_ready_o` = (state==IDLE) & granted N & `reqN_valid_i`. At most one ready is high per cycle.
  - On handshake: capture src1, src2 and ctrl into operand registers, record `id`, set `prio` to the non-granted requester, and go to EXEC.
- **EXEC:**
  - `alu_*_o` carry the operand registers. They are driven from the registers in all states; the registers change only on handshake.
  - At end of cycle, capture `alu_result_i` and `alu_zero_i` into `rsp_result_o` and `rsp_zero_o`, then go to RESP.
- **RESP:**
  - `rsp_valid_o` = 1.
  - `rsp_id_o`, `rsp_result_o` and `rsp_zero_o` hold stable while `rsp_ready_i` = 0.
  - On `rsp_ready_i` = 1, go to IDLE.
- **Control codes:** passed through unmodified, including codes outside 0000/0001/0010/0110. Result semantics are the ALU's.
- **Requester protocol:** a requester holds valid and payload stable until ready. The arbiter never drops an accepted operation.
- **No preemption:** a valid arriving during EXEC or RESP waits. It is not overtaken by a later request from the same requester.

## Timing
- **Reset values** (rst_i low, asynchronous):
  - State = IDLE; `prio` = RESET_PRIO.
  - Operand registers = 0 and `alu_ctrl_o` = 4'b0000.
  - `rsp_valid_o` = 0, `rsp_id_o` = 0, `rsp_result_o` = 0, `rsp_zero_o` = 0.
  - Both ready outputs = 0.
- **Reset mid-operation:** reset in EXEC or RESP discards the operation. There is no response and no ready until rst_i is high and the FSM is in IDLE.
- **Latency:**
  - Request handshake at edge N.
  - EXEC during cycle N+1.
  - `rsp_valid_o` high from cycle N+2.
- **Minimum issue interval:** 3 cycles (IDLE, EXEC, RESP with `rsp_ready_i` held high). The next accept occurs in the IDLE cycle after the response handshake.
- **Response stall:** `rsp_ready_i` low holds RESP indefinitely; no new request is accepted.
- **Simultaneous requests:** both valids high in IDLE. Requester `prio` is served, then the other is served on the next IDLE.
- **Continuous requests:** with both valids held high, grants strictly alternate.
- **Combinational paths:**
  - ready depends combinationally on valid and state only. No combinational path from `rsp_ready_i` to any req ready.
  - The ALU path is purely combinational within EXEC; the ALU must settle in one cycle.

## Test plan
- **Single add:** req0 src1=0x00000005, src2=0x00000003, ctrl=0010, rsp_ready=1 -> req0_ready high 1 cycle; rsp_valid at N+2 with id=0, result=0x00000008, zero=0.
- **Subtract to zero:** req1 src1=src2=0x12345678, ctrl=0110 -> id=1, result=0, zero=1.
- **Simultaneous after reset** (RESET_PRIO=0): both valid, req0 AND 0xF0F0F0F0&0xFF00FF00, req1 OR 0x0F&0xF0 -> first response id=0 result=0xF000F000; second response id=1 result=0x000000FF; req1 waits through the full req0 transaction.
- **Continuous contention:** both valids held high for 4 operations -> grant order 0,1,0,1; issue interval 3 cycles each.
- **Response stall:** rsp_ready=0 for 5 cycles with req1 pending -> rsp fields stable, req1_ready stays 0; after rsp_ready=1, req1 accepted in the following IDLE cycle.
- **Reset mid-operation:** rst_i low during EXEC of req0 ctrl=0111 (src1=1, src2=2) -> all outputs at reset values immediately; no response after release; the next request completes normally with result=0x00000001 for slt 1<2.
